// File: rtl/decl_check_if.sv
// rtl/decl_check_if.sv - character stream in, declaration verdict out
interface decl_check_if #(
  parameter int CNT_W = 8
);
  logic [7:0]       in;
  logic             in_valid;
  logic             out;
  logic             err;
  logic [CNT_W-1:0] count;

  modport master (output in, in_valid, input out, err, count);
  modport slave  (input in, in_valid, output out, err, count);
endinterface

// File: rtl/decl_check.sv
// rtl/decl_check.sv - recognises "int/char id {, id} ;" declarations in an ASCII stream
module decl_check #(
  parameter int MAX_ID_LEN  = 31,
  parameter int CNT_W       = 8,
  parameter int ENABLE_CHAR = 1
) (
  input  logic        clk,
  input  logic        reset,
  decl_check_if.slave bus
);
  localparam int LEN_W = $clog2(MAX_ID_LEN + 2);
  localparam logic [LEN_W-1:0] LEN_SAT = LEN_W'(MAX_ID_LEN + 1);

  typedef enum logic [2:0] {IDLE, KW, KW_SP, PRE_ID, ID, POST_ID, COMMA, SKIP} state_t;

  state_t                state_q;
  logic                  kw_char_q;
  logic [1:0]            kw_idx_q;
  logic [LEN_W-1:0]      len_q;
  logic [3:0][7:0]       buf_q;
  logic [CNT_W-1:0]      cnt_q;
  logic [CNT_W-1:0]      count_q;
  logic                  out_q;
  logic                  err_q;

  logic [7:0]            c;
  logic                  c_ws, c_alpha, c_digit;
  logic [7:0]            kw_exp;
  logic                  kw_last;
  logic                  is_int_kw, is_char_kw, id_ok;
  logic [LEN_W-1:0]      len_d;
  logic [CNT_W-1:0]      cnt_d;

  assign c       = bus.in;
  assign c_ws    = (c == 8'h20) || (c == 8'h09) || (c == 8'h0A) || (c == 8'h0D);
  assign c_alpha = (c >= "A" && c <= "Z") || (c >= "a" && c <= "z") || (c == "_");
  assign c_digit = (c >= "0" && c <= "9");

  always_comb begin
    kw_exp = 8'h00;
    if (kw_char_q) begin
      case (kw_idx_q)
        2'd0: kw_exp = "c";
        2'd1: kw_exp = "h";
        2'd2: kw_exp = "a";
        default: kw_exp = "r";
      endcase
    end else begin
      case (kw_idx_q)
        2'd0: kw_exp = "i";
        2'd1: kw_exp = "n";
        default: kw_exp = "t";
      endcase
    end
  end
  assign kw_last = kw_char_q ? (kw_idx_q == 2'd3) : (kw_idx_q == 2'd2);

  // Only four characters are buffered; the exact-length gate makes that sufficient.
  assign is_int_kw  = (len_q == LEN_W'(3)) && (buf_q[0] == "i") && (buf_q[1] == "n")
                      && (buf_q[2] == "t");
  assign is_char_kw = (ENABLE_CHAR != 0) && (len_q == LEN_W'(4)) && (buf_q[0] == "c")
                      && (buf_q[1] == "h") && (buf_q[2] == "a") && (buf_q[3] == "r");
  assign id_ok      = (len_q <= LEN_W'(MAX_ID_LEN)) && !is_int_kw && !is_char_kw;
  assign len_d      = (len_q == LEN_SAT) ? len_q : len_q + LEN_W'(1);
  assign cnt_d      = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      kw_char_q <= 1'b0;
      kw_idx_q  <= 2'd0;
      len_q     <= '0;
      buf_q     <= '0;
      cnt_q     <= '0;
      count_q   <= '0;
      out_q     <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      out_q <= 1'b0;
      err_q <= 1'b0;
      if (bus.in_valid) begin
        case (state_q)
          IDLE: begin
            cnt_q <= '0;
            if (c == "i") begin
              state_q   <= KW;
              kw_char_q <= 1'b0;
              kw_idx_q  <= 2'd1;
            end else if (c == "c" && ENABLE_CHAR != 0) begin
              state_q   <= KW;
              kw_char_q <= 1'b1;
              kw_idx_q  <= 2'd1;
            end else if (!c_ws && c != ";") begin
              state_q <= SKIP;
            end
          end
          KW: begin
            if (c == kw_exp) begin
              if (kw_last) state_q <= KW_SP;
              else         kw_idx_q <= kw_idx_q + 2'd1;
            end else if (c == ";") begin
              err_q   <= 1'b1;
              state_q <= IDLE;
            end else begin
              state_q <= SKIP;
            end
          end
          KW_SP: begin
            if (c_ws) state_q <= PRE_ID;
            else if (c == ";") begin
              err_q   <= 1'b1;
              state_q <= IDLE;
            end else state_q <= SKIP;
          end
          PRE_ID, COMMA: begin
            if (c_alpha) begin
              state_q <= ID;
              len_q   <= LEN_W'(1);
              buf_q   <= {24'h0, c};
            end else if (c == ";") begin
              err_q   <= 1'b1;
              state_q <= IDLE;
            end else if (!c_ws) begin
              state_q <= SKIP;
            end
          end
          ID: begin
            if (c_alpha || c_digit) begin
              len_q <= len_d;
              if (len_q < LEN_W'(4)) buf_q[len_q[1:0]] <= c;
            end else if (c_ws || c == ",") begin
              if (id_ok) begin
                cnt_q   <= cnt_d;
                state_q <= c_ws ? POST_ID : COMMA;
              end else state_q <= SKIP;
            end else if (c == ";") begin
              state_q <= IDLE;
              if (id_ok) begin
                out_q   <= 1'b1;
                count_q <= cnt_d;
              end else err_q <= 1'b1;
            end else state_q <= SKIP;
          end
          POST_ID: begin
            if (c == ",") state_q <= COMMA;
            else if (c == ";") begin
              out_q   <= 1'b1;
              count_q <= cnt_q;
              state_q <= IDLE;
            end else if (!c_ws) state_q <= SKIP;
          end
          default: begin
            if (c == ";") begin
              err_q   <= 1'b1;
              state_q <= IDLE;
            end
          end
        endcase
      end
    end
  end

  assign bus.out   = out_q;
  assign bus.err   = err_q;
  assign bus.count = count_q;
endmodule
